// File: rtl/kamus_core.sv
// kamus_core: multi-cycle, non-pipelined RV32I integer core.
// Each instruction spends one cycle in each of FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
package kamus_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

module kamus_core
  import kamus_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] l1i_instr_data_i,
  output logic [31:0] l1i_instr_addr_o,
  output logic        l1d_wr_en_o,
  output logic [31:0] l1d_addr_o,
  input  logic [31:0] l1d_rd_data_i,
  output logic [31:0] l1d_wr_data_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_t;

  state_t state, next_state;

  logic [31:0] pc, ir;
  logic [31:0] regs [0:31];
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] alu_res, next_pc, load_val;
  logic [31:0] d_addr, d_wr_data;

  logic [6:0]  opcode;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [2:0]  funct3;
  logic [31:0] imm_dec, op_b, alu_out, load_ext, store_ext;
  logic [4:0]  shamt;
  logic        taken, wb_en;

  assign opcode  = ir[6:0];
  assign rd_idx  = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1_idx = ir[19:15];
  assign rs2_idx = ir[24:20];

  assign l1i_instr_addr_o = pc;
  assign l1d_addr_o       = d_addr;
  assign l1d_wr_data_o    = d_wr_data;
  // Derived from state so an asynchronous reset drops the strobe at once.
  assign l1d_wr_en_o      = (state == S_MEMORY) && (opcode == OPC_STORE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     next_state = S_DECODE;
      S_DECODE:    next_state = S_EXECUTE;
      S_EXECUTE:   next_state = S_MEMORY;
      S_MEMORY:    next_state = S_WRITEBACK;
      S_WRITEBACK: next_state = S_FETCH;
      default:     next_state = S_FETCH;
    endcase
  end

  always_comb begin
    imm_dec = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_dec = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm_dec = {ir[31:12], 12'b0};
      OPC_JAL:    imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    imm_dec = '0;
    endcase
  end

  assign op_b  = (opcode == OPC_OP) ? rs2_val : imm;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_out = '0;
    case (funct3)
      F3_ADD_SUB: alu_out = (opcode == OPC_OP && ir[30]) ? rs1_val - op_b : rs1_val + op_b;
      F3_SLL:     alu_out = rs1_val << shamt;
      F3_SLT:     alu_out = {31'b0, $signed(rs1_val) < $signed(op_b)};
      F3_SLTU:    alu_out = {31'b0, rs1_val < op_b};
      F3_XOR:     alu_out = rs1_val ^ op_b;
      F3_SRL_SRA: alu_out = ir[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      F3_OR:      alu_out = rs1_val | op_b;
      F3_AND:     alu_out = rs1_val & op_b;
      default:    alu_out = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val < rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    store_ext = rs2_val;
    case (funct3)
      F3_SB:   store_ext = {24'b0, rs2_val[7:0]};
      F3_SH:   store_ext = {16'b0, rs2_val[15:0]};
      default: store_ext = rs2_val;
    endcase
  end

  always_comb begin
    load_ext = l1d_rd_data_i;
    case (funct3)
      F3_LB:   load_ext = {{24{l1d_rd_data_i[7]}}, l1d_rd_data_i[7:0]};
      F3_LH:   load_ext = {{16{l1d_rd_data_i[15]}}, l1d_rd_data_i[15:0]};
      F3_LBU:  load_ext = {24'b0, l1d_rd_data_i[7:0]};
      F3_LHU:  load_ext = {16'b0, l1d_rd_data_i[15:0]};
      default: load_ext = l1d_rd_data_i;
    endcase
  end

  always_comb begin
    wb_en = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: wb_en = 1'b1;
      default: wb_en = 1'b0;
    endcase
  end

  // Architectural state: PC, instruction register and register file.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
      ir <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (state == S_FETCH) ir <= l1i_instr_data_i;
      if (state == S_WRITEBACK) begin
        if (wb_en && rd_idx != 5'd0)
          regs[rd_idx] <= (opcode == OPC_LOAD) ? load_val : alu_res;
        pc <= next_pc;
      end
    end
  end

  // Per-instruction working registers filled in DECODE, EXECUTE and MEMORY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs1_val   <= '0;
      rs2_val   <= '0;
      imm       <= '0;
      alu_res   <= '0;
      next_pc   <= '0;
      load_val  <= '0;
      d_addr    <= '0;
      d_wr_data <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          rs1_val <= (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
          rs2_val <= (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];
          imm     <= imm_dec;
        end
        S_EXECUTE: begin
          next_pc <= pc + 32'd4;
          case (opcode)
            OPC_OP, OPC_OP_IMM: alu_res <= alu_out;
            OPC_LUI:   alu_res <= imm;
            OPC_AUIPC: alu_res <= pc + imm;
            OPC_JAL: begin
              alu_res <= pc + 32'd4;
              next_pc <= pc + imm;
            end
            OPC_JALR: begin
              alu_res <= pc + 32'd4;
              next_pc <= (rs1_val + imm) & ~32'd1;
            end
            OPC_BRANCH: if (taken) next_pc <= pc + imm;
            OPC_LOAD:   d_addr <= rs1_val + imm;
            OPC_STORE: begin
              d_addr    <= rs1_val + imm;
              d_wr_data <= store_ext;
            end
            default: ;
          endcase
        end
        S_MEMORY: if (opcode == OPC_LOAD) load_val <= load_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kamus_core.sv
// Self-checking bench for kamus_core: directed program fragments plus random
// instruction streams compared against an instruction-level reference model.
module tb_kamus_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_data, rd_data;
  logic [31:0] instr_addr, d_addr, wr_data;
  logic        wr_en;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference architectural state
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc, m_addr, m_wdata;

  kamus_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .l1i_instr_data_i (instr_data),
    .l1i_instr_addr_o (instr_addr),
    .l1d_wr_en_o      (wr_en),
    .l1d_addr_o       (d_addr),
    .l1d_rd_data_i    (rd_data),
    .l1d_wr_data_o    (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = 32'h0; m_addr = '0; m_wdata = '0;
  endtask

  // Executes one instruction on the reference state; returns whether a store happens.
  task automatic model_exec(input logic [31:0] ins, input logic [31:0] rdv, output logic store);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, res, npc;
    logic        wr;
    int          immi, imms, immb, immj;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
    a = m_regs[rs1]; b = m_regs[rs2];
    immi = $signed(ins[31:20]);
    s12 = {ins[31:25], ins[11:7]}; imms = s12;
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; immb = b13;
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; immj = j21;
    npc = m_pc + 4; wr = 1'b0; res = '0; store = 1'b0;
    case (ins[6:0])
      7'h33, 7'h13: begin
        logic [31:0] y;
        y = (ins[6:0] == 7'h33) ? b : immi;
        wr = 1'b1;
        case (f3)
          0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - y : a + y;
          1: res = a << y[4:0];
          2: res = ($signed(a) < $signed(y)) ? 1 : 0;
          3: res = (a < y) ? 1 : 0;
          4: res = a ^ y;
          5: res = ins[30] ? $signed(a) >>> y[4:0] : a >> y[4:0];
          6: res = a | y;
          default: res = a & y;
        endcase
      end
      7'h03: begin
        m_addr = a + immi; wr = 1'b1;
        case (f3)
          0: res = $signed(rdv[7:0]);
          1: res = $signed(rdv[15:0]);
          4: res = rdv & 32'hFF;
          5: res = rdv & 32'hFFFF;
          default: res = rdv;
        endcase
      end
      7'h23: begin
        m_addr = a + imms; store = 1'b1;
        m_wdata = (f3 == 0) ? (b & 32'hFF) : (f3 == 1) ? (b & 32'hFFFF) : b;
      end
      7'h63: begin
        logic t;
        case (f3)
          0: t = (a == b);
          1: t = (a != b);
          4: t = ($signed(a) < $signed(b));
          5: t = ($signed(a) >= $signed(b));
          6: t = (a < b);
          default: t = (a >= b);
        endcase
        if (t) npc = m_pc + immb;
      end
      7'h37: begin res = ins & 32'hFFFF_F000; wr = 1'b1; end
      7'h17: begin res = m_pc + (ins & 32'hFFFF_F000); wr = 1'b1; end
      7'h6F: begin res = m_pc + 4; npc = m_pc + immj; wr = 1'b1; end
      7'h67: begin res = m_pc + 4; npc = (a + immi) & 32'hFFFF_FFFE; wr = 1'b1; end
      default: ;
    endcase
    if (wr && rd != 0) m_regs[rd] = res;
    m_pc = npc;
  endtask

  // Presents one instruction for its five cycles and checks the visible effects.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] rdv);
    logic [31:0] pc0;
    logic        exp_store, moved;
    int unsigned pulses;
    pc0 = instr_addr;
    instr_data = ins; rd_data = rdv;
    model_exec(ins, rdv, exp_store);
    pulses = 0; moved = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (wr_en) pulses++;
      if (c < 4 && instr_addr !== pc0) moved = 1'b1;
    end
    check("pc_hold", {31'b0, moved}, 32'd0);
    check("pc_next", instr_addr, m_pc);
    check("wr_pulses", pulses, {31'b0, exp_store});
    check("d_addr", d_addr, m_addr);
    check("d_wdata", wr_data, m_wdata);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [2:0]  lf3 [5];
    logic [2:0]  bf3 [6];
    logic [6:0]  nops [3];
    lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    nops = '{7'h00, 7'h0F, 7'h73};
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom); imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                      rs2, rs1, f3, rd);
      1: begin
        if (f3 == 1) imm = {7'h00, imm[4:0]};
        if (f3 == 5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      2: return enc_i(imm, rs1, lf3[$urandom_range(0, 4)], rd, 7'h03);
      3: return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
      4: return enc_b({13'($urandom) & 13'h1FFE}, rs2, rs1, bf3[$urandom_range(0, 5)]);
      5: return {20'($urandom), rd, 7'h37};
      6: return {20'($urandom), rd, 7'h17};
      7: return enc_j(21'($urandom) & 21'h1FFFFE, rd);
      8: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
      default: return {25'($urandom), nops[$urandom_range(0, 2)]};
    endcase
  endfunction

  task automatic dump_regs();
    for (int r = 1; r < 32; r++) run_instr(enc_s(12'd0, 5'(r), 5'd0, 3'd2), 32'h0);
  endtask

  initial begin
    rst = 1'b1; instr_data = '0; rd_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pc", instr_addr, 32'h0);
    check("rst_we", {31'b0, wr_en}, 32'd0);
    check("rst_addr", d_addr, 32'h0);
    check("rst_wdata", wr_data, 32'h0);

    run_instr(32'h0000_0000, 32'h0);
    check("nop_pc4", instr_addr, 32'h4);

    run_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13), 32'h0);
    run_instr(enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'h13), 32'h0);
    run_instr(enc_i(12'd3, 5'd0, 3'd0, 5'd3, 7'h13), 32'h0);
    for (int f = 2; f >= 0; f--) begin
      run_instr(enc_s(12'd1, 5'd2, 5'd1, 3'(f)), 32'h0);
      check("st_addr", d_addr, 32'h2);
      check("st_data", wr_data, 32'h2);
    end
    run_instr({20'hFFFF1, 5'd5, 7'h37}, 32'h0);
    run_instr(enc_i(12'h234, 5'd5, 3'd0, 5'd5, 7'h13), 32'h0);
    run_instr(enc_s(12'd1, 5'd5, 5'd1, 3'd1), 32'h0);
    check("sh_trunc", wr_data, 32'h0000_1234);

    begin
      logic [2:0]  lf [5];
      logic [31:0] ld [5];
      logic [31:0] ex [5];
      lf = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd4};
      ld = '{32'h0111_111F, 32'h0111_111F, 32'h0111_111F, 32'h0000_8080, 32'h0000_8080};
      ex = '{32'h0111_111F, 32'h0000_111F, 32'h0000_001F, 32'hFFFF_FF80, 32'h0000_0080};
      for (int k = 0; k < 5; k++) begin
        run_instr(enc_i(12'd1, 5'd0, lf[k], 5'd31, 7'h03), ld[k]);
        run_instr(enc_s(12'd1, 5'd31, 5'd1, 3'd2), 32'hDEAD_BEEF);
        check("load_ext", wr_data, ex[k]);
      end
    end

    begin
      logic [31:0] p;
      p = instr_addr;
      run_instr(enc_b(13'd30, 5'd30, 5'd0, 3'd0), 32'h0);
      check("beq_taken", instr_addr, p + 32'd30);
      p = instr_addr;
      run_instr(enc_b(13'd30, 5'd30, 5'd0, 3'd1), 32'h0);
      check("bne_fall", instr_addr, p + 32'd4);
    end

    run_instr({20'h00001, 5'd29, 7'h37}, 32'h0);
    run_instr(enc_i(12'd1, 5'd29, 3'd0, 5'd28, 7'h13), 32'h0);
    run_instr(enc_s(12'd1, 5'd28, 5'd1, 3'd2), 32'h0);
    check("lui_data", wr_data, 32'h0000_1001);
    check("lui_addr", d_addr, 32'h2);

    for (int n = 0; n < 400; n++) run_instr(rand_instr(), $urandom);
    dump_regs();

    // Reset during MEMORY of a store aborts it.
    instr_data = enc_s(12'd1, 5'd2, 5'd1, 3'd2);
    repeat (3) @(posedge clk);
    #1 check("mid_we", {31'b0, wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we", {31'b0, wr_en}, 32'd0);
    check("abort_pc", instr_addr, 32'h0);
    check("abort_addr", d_addr, 32'h0);
    check("abort_wdata", wr_data, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    dump_regs();

    for (int n = 0; n < 100; n++) run_instr(rand_instr(), $urandom);
    dump_regs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kamus_core.md
Name: kamus_core

Overview:
- Multi-cycle RV32I integer core, single-issue, non-pipelined.
- Fetches from an L1 instruction port and accesses data through an L1 data port.
- Each instruction takes exactly 5 clock cycles (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK).
- Opcode and funct3 encodings (R/I/L/S/B/LUI types, F3_* codes) come from kamus_pkg.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i, input, 1, core clock; all state updates on rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- l1i_instr_data_i, input, 32, instruction word at l1i_instr_addr_o; combinational read, sampled in FETCH.
- l1i_instr_addr_o, output, 32, current PC (byte address).
- l1d_wr_en_o, output, 1, data write strobe.
- l1d_addr_o, output, 32, data address (rs1 + imm).
- l1d_rd_data_i, input, 32, load data; combinational read, sampled in MEMORY.
- l1d_wr_data_o, output, 32, store data.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - PC = RESET_PC; FSM state = FETCH.
  - x1..x31 = 0; instruction register = 0.
  - l1d_wr_en_o = 0, l1d_addr_o = 0, l1d_wr_data_o = 0.
  - Reset asserted mid-instruction aborts it: no register write, no memory write, no PC update.
- FSM advances one state per cycle: FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH. There are no stalls.
- FETCH: latch l1i_instr_data_i into the instruction register.
- DECODE:
  - Read rs1/rs2 from a 32x32 register file; x0 always reads 0, and writes to x0 are ignored.
  - Generate the immediate for the I/S/B/U/J format.
- EXECUTE: ALU computes the result or address; branch comparison is evaluated.
  - Loads and stores register l1d_addr_o = rs1 + sign-extended imm.
  - Stores register l1d_wr_data_o:
    - SW: rs2.
    - SH: zero-extended rs2[15:0].
    - SB: zero-extended rs2[7:0].
  - l1d_addr_o and l1d_wr_data_o hold their values until the next load or store updates them.
- MEMORY:
  - l1d_wr_en_o = 1 for exactly this one cycle, stores only.
  - Loads capture l1d_rd_data_i, then extend:
    - LW: full word.
    - LH: sign-extended [15:0].
    - LHU: zero-extended [15:0].
    - LB: sign-extended [7:0].
    - LBU: zero-extended [7:0].
- WRITEBACK: write rd, then update the PC.
  - rd written for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; JAL/JALR write pc+4.
  - PC update:
    - Taken branch: pc + B-imm.
    - JAL: pc + J-imm.
    - JALR: (rs1 + imm) & ~1.
    - Otherwise: pc + 4.
  - l1i_instr_addr_o changes exactly once per instruction, at the end of WRITEBACK.
- Supported instructions:
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, SLLI, SRLI, SRAI, ORI, ANDI.
  - LOAD: LB, LH, LW, LBU, LHU. STORE: SB, SH, SW.
  - BRANCH: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LUI (rd = imm[31:12] << 12), AUIPC, JAL, JALR.
- Any other opcode (including all-zero, FENCE, SYSTEM) executes as a NOP: no writes, PC += 4.
- Arithmetic is 32-bit wraparound. Shift amount uses the low 5 bits.
- No misalignment checking; addresses are passed through unmodified. No byte enables.

Test Plan:
- Reset, then instruction 0x00000000 for 5 cycles -> l1i_instr_addr_o goes 0 -> 4; l1d_wr_en_o stays 0.
- Apply each for 5 cycles: ADDI x1,x0,1; ADDI x2,x0,2; ADDI x3,x0,3. Then SW x2,1(x1) -> l1d_addr_o = 0x2, l1d_wr_data_o = 0x2, l1d_wr_en_o pulses once.
- SH x2,1(x1) and SB x2,1(x1) -> l1d_addr_o = 0x2, l1d_wr_data_o = 0x2. SH with rs2 = 0xFFFF1234 -> wr_data 0x00001234.
- l1d_rd_data_i = 0x0111111F; LW x31,1(x0) / LH / LB, each followed by SW x31 -> stored data 0x0111111F, then 0x0000111F, then 0x0000001F. With rd_data 0x0000_8080: LB gives 0xFFFFFF80, LBU gives 0x00000080.
- BEQ x0,x30,+30 with x30 = 0 -> after 5 cycles PC = old PC + 30. BNE with the same operands -> PC + 4.
- LUI x29,0x1; ADDI x28,x29,1; SW x28,1(x1) -> l1d_wr_data_o = 0x00001001, l1d_addr_o = 0x2.
- Assert rst_i during MEMORY of a store -> l1d_wr_en_o drops immediately; PC = RESET_PC; registers cleared.
